// File: rtl/fight_pkg.sv
// rtl/fight_pkg.sv - shared action codes, FSM states and defaults for the round controller
package fight_pkg;

  localparam logic [2:0] ACT_NOP    = 3'b000;
  localparam logic [2:0] ACT_LEFT   = 3'b001;
  localparam logic [2:0] ACT_RIGHT  = 3'b010;
  localparam logic [2:0] ACT_ATTACK = 3'b011;
  localparam logic [2:0] ACT_DEFEND = 3'b100;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 200;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_LOAD,
    ST_FIRE,
    ST_RELEASE,
    ST_HALT
  } round_state_e;

  function automatic logic is_busy_state(round_state_e s);
    return (s == ST_LOAD) || (s == ST_FIRE) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/fight_round_ctrl_if.sv
// rtl/fight_round_ctrl_if.sv - player request / core action bundle of the round controller
interface fight_round_ctrl_if #(
  parameter int ACTION_W = 3
);

  logic                req1;
  logic [ACTION_W-1:0] code1;
  logic                req2;
  logic [ACTION_W-1:0] code2;
  logic                game_over;
  logic [ACTION_W-1:0] action1;
  logic [ACTION_W-1:0] action2;
  logic                control;
  logic [7:0]          round_cnt;
  logic                busy;

  modport master (
    output req1, code1, req2, code2, game_over,
    input  action1, action2, control, round_cnt, busy
  );

  modport slave (
    input  req1, code1, req2, code2, game_over,
    output action1, action2, control, round_cnt, busy
  );

endinterface

// File: rtl/action_debounce.sv
// rtl/action_debounce.sv - per-player request debouncer that commits one stable action code
import fight_pkg::*;

module action_debounce #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACTION_W        = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                req,
  input  logic [ACTION_W-1:0] code,
  output logic                committed,
  output logic [ACTION_W-1:0] committed_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]       cnt_q, cnt_d, run;
  logic [ACTION_W-1:0] last_code_q, last_code_d;
  logic [ACTION_W-1:0] latched_q, latched_d;
  logic                committed_q, committed_d;
  logic                hit;

  always_comb begin
    // run is the length of the stable-request streak including this cycle
    run         = (cnt_q != '0 && code == last_code_q) ? cnt_q + CW'(1) : CW'(1);
    hit         = enable && !committed_q && req && (run == CW'(DEBOUNCE_CYCLES));
    cnt_d       = cnt_q;
    committed_d = committed_q;
    latched_d   = latched_q;
    last_code_d = code;
    if (clear) begin
      cnt_d       = '0;
      committed_d = 1'b0;
    end else if (enable && !committed_q) begin
      cnt_d = req ? run : '0;
      if (hit) begin
        committed_d = 1'b1;
        latched_d   = code;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      last_code_q <= '0;
      latched_q   <= '0;
      committed_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_code_q <= last_code_d;
      latched_q   <= latched_d;
      committed_q <= committed_d;
    end
  end

  // A commit landing this cycle is visible immediately so it can win against a timeout.
  assign committed      = committed_q | hit;
  assign committed_code = committed_q ? latched_q : code;

endmodule

// File: rtl/fight_round_ctrl.sv
// rtl/fight_round_ctrl.sv - collects one debounced action per player and issues one step pulse per round
import fight_pkg::*;

module fight_round_ctrl #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int ACTION_W        = 3
) (
  input  logic clk,
  input  logic reset,
  fight_round_ctrl_if.slave bus
);

  localparam int                  TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [ACTION_W-1:0] NOP = ACTION_W'(ACT_NOP);

  round_state_e        state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [ACTION_W-1:0] action1_q, action1_d, action2_q, action2_d;
  logic [7:0]          round_q, round_d;
  logic                control_q, control_d;
  logic                busy_q, busy_d;

  logic                deb_enable, deb_clear;
  logic                com1, com2;
  logic [ACTION_W-1:0] ccode1, ccode2;

  assign deb_enable = (state_q == ST_COLLECT);
  assign deb_clear  = (state_q == ST_RELEASE);

  action_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTION_W(ACTION_W)) u_deb1 (
    .clk(clk), .reset(reset), .enable(deb_enable), .clear(deb_clear),
    .req(bus.req1), .code(bus.code1), .committed(com1), .committed_code(ccode1)
  );

  action_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTION_W(ACTION_W)) u_deb2 (
    .clk(clk), .reset(reset), .enable(deb_enable), .clear(deb_clear),
    .req(bus.req2), .code(bus.code2), .committed(com2), .committed_code(ccode2)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    action1_d = action1_q;
    action2_d = action2_q;
    round_d   = round_q;
    if (bus.game_over && state_q != ST_FIRE) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          timer_d = timer_q + TW'(1);
          // Actions load on entry to LOAD so they lead control by a full cycle.
          if (com1 && com2) begin
            state_d   = ST_LOAD;
            timer_d   = '0;
            action1_d = ccode1;
            action2_d = ccode2;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timer_d = '0;
            if (com1 ^ com2) begin
              state_d   = ST_LOAD;
              action1_d = com1 ? ccode1 : NOP;
              action2_d = com2 ? ccode2 : NOP;
            end
          end
        end
        ST_LOAD: state_d = ST_FIRE;
        ST_FIRE: begin
          round_d = round_q + 8'd1;
          state_d = bus.game_over ? ST_HALT : ST_RELEASE;
        end
        ST_RELEASE: begin
          timer_d = '0;
          if (!bus.req1 && !bus.req2) state_d = ST_COLLECT;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_COLLECT;
      endcase
    end
    control_d = (state_d == ST_FIRE);
    busy_d    = is_busy_state(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_COLLECT;
      timer_q   <= '0;
      action1_q <= NOP;
      action2_q <= NOP;
      round_q   <= '0;
      control_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      action1_q <= action1_d;
      action2_q <= action2_d;
      round_q   <= round_d;
      control_q <= control_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.action1   = action1_q;
  assign bus.action2   = action2_q;
  assign bus.control   = control_q;
  assign bus.round_cnt = round_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fight_round_ctrl.sv
// tb/tb_fight_round_ctrl.sv - self-checking bench for fight_round_ctrl
module tb_fight_round_ctrl;
  import fight_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fight_round_ctrl_if #(.ACTION_W(3)) bus();

  fight_round_ctrl #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .ACTION_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  int         pulse_cnt = 0, wide_cnt = 0, unstable_cnt = 0;
  logic [2:0] pulse_a1 = '0, pulse_a2 = '0, prev_a1 = '0, prev_a2 = '0;
  logic       prev_ctl = 1'b0;

  // pulse observer: width and the actions seen in the cycle before each rise
  always @(negedge clk) begin
    if (bus.control) begin
      if (prev_ctl) wide_cnt <= wide_cnt + 1;
      else begin
        pulse_cnt <= pulse_cnt + 1;
        pulse_a1  <= bus.action1;
        pulse_a2  <= bus.action2;
        if (bus.action1 !== prev_a1 || bus.action2 !== prev_a2) unstable_cnt <= unstable_cnt + 1;
      end
    end
    prev_ctl <= bus.control;
    prev_a1  <= bus.action1;
    prev_a2  <= bus.action2;
  end

  typedef struct {
    bit         on1;
    logic [2:0] c1;
    bit         on2;
    logic [2:0] c2;
    int         exp_p;
    logic [2:0] e1;
    logic [2:0] e2;
  } vec_t;

  vec_t       vecs[6];
  logic       q1r[$], q2r[$];
  logic [2:0] q1c[$], q2c[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req1 = 1'b0; bus.req2 = 1'b0; bus.code1 = '0; bus.code2 = '0; bus.game_over = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drive_cycle(input int i, input bit on1, input logic [2:0] f1,
                             input bit on2, input logic [2:0] f2);
    if (i < q1r.size()) begin bus.req1 = q1r[i]; bus.code1 = q1c[i]; end
    else begin bus.req1 = on1; bus.code1 = f1; end
    if (i < q2r.size()) begin bus.req2 = q2r[i]; bus.code2 = q2c[i]; end
    else begin bus.req2 = on2; bus.code2 = f2; end
  endtask

  task automatic drive_round(input bit on1, input logic [2:0] f1, input bit on2,
                             input logic [2:0] f2, input int hold, output int delta);
    int start, i, n;
    start = pulse_cnt;
    i = 0;
    while (pulse_cnt == start && i < 3 * TMO) begin
      drive_cycle(i, on1, f1, on2, f2); tick(); i++;
    end
    for (int h = 0; h < hold; h++) begin
      drive_cycle(i, on1, f1, on2, f2); tick(); i++;
    end
    bus.req1 = 1'b0; bus.req2 = 1'b0;
    n = 0;
    tick();
    while (bus.busy && n < 10) begin tick(); n++; end
    if (bus.busy) check("release_bound", int'(bus.busy), 0);
    delta = pulse_cnt - start;
  endtask

  // bounce prefix: short streaks (< DEB) split by gaps or code changes, then the final code
  task automatic gen_prefix(input int p, input logic [2:0] fin);
    logic       r[$];
    logic [2:0] k[$];
    logic [2:0] code, last;
    int         nseg, len, gap;
    bit         chained;
    chained = 1'b0;
    last = '0;
    nseg = $urandom_range(0, 2);
    for (int s = 0; s < nseg; s++) begin
      do code = 3'($urandom_range(0, 7)); while (chained && code == last);
      len = $urandom_range(1, DEB - 1);
      for (int j = 0; j < len; j++) begin r.push_back(1'b1); k.push_back(code); end
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin r.push_back(1'b0); k.push_back(code); end
      chained = (gap == 0);
      last = code;
    end
    if (chained && fin == last) begin r.push_back(1'b0); k.push_back(fin); end
    if (p == 1) begin q1r = r; q1c = k; end
    else begin q2r = r; q2c = k; end
  endtask

  initial begin
    int d, start, exp_rounds, n, total;
    bit on1, on2;
    logic [2:0] c1, c2;

    vecs[0] = '{1'b1, ACT_ATTACK, 1'b1, ACT_DEFEND, 1, ACT_ATTACK, ACT_DEFEND};
    vecs[1] = '{1'b1, ACT_LEFT,   1'b1, ACT_RIGHT,  1, ACT_LEFT,   ACT_RIGHT};
    vecs[2] = '{1'b1, ACT_RIGHT,  1'b0, ACT_LEFT,   1, ACT_RIGHT,  ACT_NOP};
    vecs[3] = '{1'b0, ACT_DEFEND, 1'b1, ACT_ATTACK, 1, ACT_NOP,    ACT_ATTACK};
    vecs[4] = '{1'b0, ACT_LEFT,   1'b0, ACT_RIGHT,  0, ACT_NOP,    ACT_NOP};
    vecs[5] = '{1'b1, ACT_DEFEND, 1'b1, ACT_NOP,    1, ACT_DEFEND, ACT_NOP};

    reset = 1'b0;
    bus.req1 = 1'b0; bus.req2 = 1'b0; bus.code1 = '0; bus.code2 = '0; bus.game_over = 1'b0;
    #12;
    check("rst_action1", int'(bus.action1), int'(ACT_NOP));
    check("rst_action2", int'(bus.action2), int'(ACT_NOP));
    check("rst_control", int'(bus.control), 0);
    check("rst_round_cnt", int'(bus.round_cnt), 0);
    check("rst_busy", int'(bus.busy), 0);
    do_reset();

    exp_rounds = 0;
    foreach (vecs[v]) begin
      q1r.delete(); q1c.delete(); q2r.delete(); q2c.delete();
      drive_round(vecs[v].on1, vecs[v].c1, vecs[v].on2, vecs[v].c2, 0, d);
      check($sformatf("vec%0d_pulses", v), d, vecs[v].exp_p);
      exp_rounds += vecs[v].exp_p;
      if (vecs[v].exp_p == 1) begin
        check($sformatf("vec%0d_action1", v), int'(pulse_a1), int'(vecs[v].e1));
        check($sformatf("vec%0d_action2", v), int'(pulse_a2), int'(vecs[v].e2));
      end
      check($sformatf("vec%0d_round_cnt", v), int'(bus.round_cnt), exp_rounds % 256);
    end

    // bounce: only the final four consecutive highs commit player 1
    q1r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    q1c = '{ACT_LEFT, ACT_LEFT, ACT_LEFT, ACT_LEFT, ACT_LEFT, ACT_LEFT, ACT_LEFT};
    q2r.delete(); q2c.delete();
    start = pulse_cnt;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(i, 1'b1, ACT_LEFT, 1'b1, ACT_DEFEND);
      tick();
      if (i == 5) check("bounce_not_yet_committed", int'(bus.busy), 0);
    end
    check("bounce_load_entered", int'(bus.busy), 1);
    check("bounce_action1_loaded", int'(bus.action1), int'(ACT_LEFT));
    check("bounce_no_early_pulse", pulse_cnt - start, 0);
    q1r.delete(); q1c.delete();
    drive_round(1'b1, ACT_LEFT, 1'b1, ACT_DEFEND, 0, d);
    check("bounce_pulses", d, 1);
    check("bounce_pulse_action1", int'(pulse_a1), int'(ACT_LEFT));

    // held buttons give one round; release and recommit gives the second
    do_reset();
    drive_round(1'b1, ACT_ATTACK, 1'b1, ACT_LEFT, 50, d);
    check("held_single_pulse", d, 1);
    drive_round(1'b1, ACT_RIGHT, 1'b1, ACT_RIGHT, 0, d);
    check("recommit_pulse", d, 1);
    check("recommit_round_cnt", int'(bus.round_cnt), 2);

    // randomized rounds against the round-level model
    do_reset();
    exp_rounds = 0;
    for (int r = 0; r < 40; r++) begin
      on1 = ($urandom_range(0, 3) != 0);
      on2 = ($urandom_range(0, 3) != 0);
      if (!on1 && !on2) on1 = 1'b1;
      c1 = 3'($urandom_range(0, 7));
      c2 = 3'($urandom_range(0, 7));
      q1r.delete(); q1c.delete(); q2r.delete(); q2c.delete();
      if (on1) gen_prefix(1, c1);
      if (on2) gen_prefix(2, c2);
      drive_round(on1, c1, on2, c2, $urandom_range(0, 3), d);
      exp_rounds++;
      check($sformatf("rnd%0d_pulses", r), d, 1);
      check($sformatf("rnd%0d_action1", r), int'(pulse_a1), on1 ? int'(c1) : int'(ACT_NOP));
      check($sformatf("rnd%0d_action2", r), int'(pulse_a2), on2 ? int'(c2) : int'(ACT_NOP));
      check($sformatf("rnd%0d_round_cnt", r), int'(bus.round_cnt), exp_rounds % 256);
    end
    q1r.delete(); q1c.delete(); q2r.delete(); q2c.delete();

    // game_over during COLLECT stops all rounds
    do_reset();
    bus.game_over = 1'b1;
    tick();
    start = pulse_cnt;
    for (int i = 0; i < 12; i++) begin drive_cycle(i, 1'b1, ACT_LEFT, 1'b1, ACT_RIGHT); tick(); end
    check("go_collect_no_pulse", pulse_cnt - start, 0);
    check("go_collect_busy", int'(bus.busy), 0);

    // game_over during FIRE: pulse completes, then halted for good
    do_reset();
    start = pulse_cnt;
    n = 0;
    while (!bus.control && n < 20) begin drive_cycle(n, 1'b1, ACT_ATTACK, 1'b1, ACT_ATTACK); tick(); n++; end
    check("go_fire_reached", int'(bus.control), 1);
    bus.game_over = 1'b1;
    tick();
    check("go_fire_control_drop", int'(bus.control), 0);
    bus.req1 = 1'b0; bus.req2 = 1'b0;
    repeat (3) tick();
    bus.game_over = 1'b0;
    for (int i = 0; i < 3 * TMO; i++) begin drive_cycle(i, 1'b1, ACT_LEFT, 1'b1, ACT_LEFT); tick(); end
    check("go_fire_pulses", pulse_cnt - start, 1);
    check("go_fire_halted_busy", int'(bus.busy), 0);

    // asynchronous reset in LOAD
    do_reset();
    drive_round(1'b1, ACT_ATTACK, 1'b1, ACT_DEFEND, 0, d);
    n = 0;
    while (!bus.busy && n < 20) begin drive_cycle(n, 1'b1, ACT_RIGHT, 1'b1, ACT_LEFT); tick(); n++; end
    check("load_reached_action1", int'(bus.action1), int'(ACT_RIGHT));
    reset = 1'b0;
    #2;
    check("async_rst_action1", int'(bus.action1), int'(ACT_NOP));
    check("async_rst_action2", int'(bus.action2), int'(ACT_NOP));
    check("async_rst_control", int'(bus.control), 0);
    check("async_rst_round_cnt", int'(bus.round_cnt), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    do_reset();

    // round counter wrap
    total = 0;
    for (int r = 0; r < 256; r++) begin
      drive_round(1'b1, ACT_ATTACK, 1'b1, ACT_DEFEND, 0, d);
      total += d;
      if (r == 254) check("wrap_round_cnt_255", int'(bus.round_cnt), 255);
    end
    check("wrap_total_pulses", total, 256);
    check("wrap_round_cnt_0", int'(bus.round_cnt), 0);

    check("pulse_width_one", wide_cnt, 0);
    check("actions_stable_before_pulse", unstable_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fight_round_ctrl.md
Name: fight_round_ctrl

Overview:
- Input stage directly upstream of the fighting-game core.
- Debounces each player's raw action request and collects one committed action per player per round.
- Presents the two committed actions on action1/action2, then issues a single registered control pulse. That pulse is the core's step enable, gated with its clock.
- Stops issuing rounds once game_over is asserted.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to commit a request (≥1).
- TIMEOUT_CYCLES, 200: cycles allowed in COLLECT before a partially committed round is forced (≥2).
- ACTION_W, 3: action code width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req1  in  1  player 1 raw request (level, may bounce)
- code1  in  ACTION_W  player 1 requested action code
- req2  in  1  player 2 raw request
- code2  in  ACTION_W  player 2 requested action code
- game_over  in  1  high when either player's lives are 0
- action1  out  ACTION_W  committed player 1 action to core
- action2  out  ACTION_W  committed player 2 action to core
- control  out  1  one-cycle step pulse to core
- round_cnt  out  8  number of issued rounds
- busy  out  1  high in LOAD, FIRE and RELEASE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=COLLECT; action1=action2=ACT_NOP (000); control=0; round_cnt=0.
  - Debounce counters, commit flags and timer all clear.
- Debounce, per player, active only in COLLECT:
  - The counter increments while req=1 and code equals the code sampled last cycle.
  - It clears when req=0 or the code changes.
  - When the counter reaches DEBOUNCE_CYCLES, the player's commit flag sets and that code is latched.
  - Once committed, further req/code activity is ignored until the next round.
- FSM states: COLLECT, LOAD, FIRE, RELEASE, HALT.
- COLLECT:
  - The timer increments each cycle.
  - Both players committed → LOAD.
  - Timer == TIMEOUT_CYCLES-1 with exactly one player committed → LOAD, and the uncommitted player's action is ACT_NOP.
  - Timer expiry with no commits → timer restarts at 0 and the FSM stays in COLLECT. No empty rounds are issued.
- LOAD:
  - action1/action2 register the latched codes; control=0.
  - Next state FIRE.
  - Actions are therefore stable one full cycle before control rises.
- FIRE:
  - control=1 for exactly this one cycle.
  - round_cnt increments, wrapping 255→0.
  - action1/action2 are held.
  - Next state RELEASE.
- RELEASE:
  - control=0.
  - Commit flags, debounce counters and timer clear.
  - Stays until req1=0 and req2=0 for one cycle, then → COLLECT. A held button never produces two rounds.
- action1/action2 hold their last issued values in every state except LOAD and reset.
- game_over=1:
  - From any state except FIRE → HALT on the next edge.
  - If seen during FIRE, the pulse completes and the transition happens on the following edge.
  - In HALT: control=0, outputs hold, and the FSM leaves only via reset.
- Simultaneous commits in the same cycle count as both committed and go to LOAD.
- A commit in the same cycle as timeout expiry counts as a commit.
- control is a direct flop output with no combinational path from inputs, which keeps the gated clock in the core glitch-free.

Decomposition:
- Shared package fight_pkg holds:
  - ACT_NOP=3'b000, ACT_LEFT=3'b001, ACT_RIGHT=3'b010, ACT_ATTACK=3'b011, ACT_DEFEND=3'b100.
  - The FSM state enum.
  - Default DEBOUNCE_CYCLES and TIMEOUT_CYCLES.
- One sub-module, action_debounce, instantiated twice (once per player). It takes clk, reset, enable, clear, req and code, and outputs committed and committed_code.

Test Plan:
1. Reset, then req1=1/code1=011 and req2=1/code2=100 held 4 cycles → action1=011 and action2=100 appear, control=1 exactly one cycle later for one cycle, round_cnt=1.
2. req1 toggling 1,1,0,1,1,1,1 with code1=001 → commit only after the final four consecutive highs; no pulse before then.
3. Only player 1 commits (010), player 2 idle → control pulses after TIMEOUT_CYCLES with action1=010 and action2=000. Neither player active → no pulse for 3×TIMEOUT_CYCLES.
4. Both requests held high for 50 cycles after a round → exactly one control pulse. Release both, then recommit → second pulse, round_cnt=2.
5. game_over=1 asserted during COLLECT, and separately during FIRE → no further pulses; the FIRE-cycle pulse still completes with width 1. reset=0 mid-LOAD → all outputs return to reset values asynchronously.
6. 256 rounds → round_cnt wraps to 0.
